// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception codes and Status/Cause bit positions.
// Shared by the exception controller, its timer and the bench.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;

  // Fixed priority: interrupt first, then the synchronous faults in pipeline order.
  function automatic logic [4:0] exc_code_sel(input logic irq, input logic ov,
                                              input logic adel, input logic ades,
                                              input logic sys, input logic bp,
                                              input logic ri);
    if (irq)       return EXC_INT;
    else if (ov)   return EXC_OV;
    else if (adel) return EXC_ADEL;
    else if (ades) return EXC_ADES;
    else if (sys)  return EXC_SYS;
    else if (bp)   return EXC_BP;
    else if (ri)   return EXC_RI;
    else           return EXC_INT;
  endfunction

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// Core <-> CP0 signal bundle: mtc0/mfc0 access, exception requests, eret, EPC/EXL.
// master = pipeline side, slave = CP0 side.
interface cp0_exception_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IRQ    = 8
);
  logic [NUM_IRQ-1:0]    interrupts;
  logic                  cop0write;
  logic [4:0]            writeaddress;
  logic [DATA_WIDTH-1:0] writecop0;
  logic [4:0]            readaddress;
  logic [DATA_WIDTH-1:0] cop0readdata;
  logic [DATA_WIDTH-1:0] pc;
  logic                  overflow;
  logic                  adel;
  logic                  ades;
  logic                  syscall;
  logic                  break_;
  logic                  ri;
  logic                  eret;
  logic                  pendingexception;
  logic [DATA_WIDTH-1:0] epc;
  logic                  exl;

  modport master (
    output interrupts, cop0write, writeaddress, writecop0, readaddress, pc,
           overflow, adel, ades, syscall, break_, ri, eret,
    input  cop0readdata, pendingexception, epc, exl
  );

  modport slave (
    input  interrupts, cop0write, writeaddress, writecop0, readaddress, pc,
           overflow, adel, ades, syscall, break_, ri, eret,
    output cop0readdata, pendingexception, epc, exl
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count runs every cycle (mtc0 load wins), flag sets on match
// after update and is cleared by an mtc0 to Compare.
module cp0_timer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count_we,
  input  logic                  compare_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0] compare,
  output logic                  timer_flag
);

  logic [DATA_WIDTH-1:0] count_nxt;

  always_comb begin
    count_nxt = count_we ? wdata : count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      compare    <= '0;
      timer_flag <= 1'b0;
    end else begin
      count <= count_nxt;
      if (compare_we) begin
        compare    <= wdata;
        timer_flag <= 1'b0;
      end else if (count_nxt == compare) begin
        timer_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 Status/Cause/EPC and exception sequencing; exception commits one edge after request.
// Optional Count/Compare timer built only when CP0_TIMER_EN is defined.
module cp0_exception_ctrl
  import cp0_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IRQ    = 8
) (
  input logic                 clk,
  input logic                 reset,
  cp0_exception_ctrl_if.slave bus
);

  logic                  ie;
  logic                  exl_q;
  logic [NUM_IRQ-1:0]    im;
  logic [4:0]            exc_code;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [NUM_IRQ-1:0]    ip;
  logic                  timer_flag;
  logic [DATA_WIDTH-1:0] count_val;
  logic [DATA_WIDTH-1:0] compare_val;
  logic                  interrupt;
  logic                  sync_req;
  logic                  pending;
  logic [4:0]            win_code;
  logic [DATA_WIDTH-1:0] status_rd;
  logic [DATA_WIDTH-1:0] cause_rd;

`ifdef CP0_TIMER_EN
  cp0_timer #(.DATA_WIDTH(DATA_WIDTH)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (bus.cop0write && bus.writeaddress == REG_COUNT),
    .compare_we (bus.cop0write && bus.writeaddress == REG_COMPARE),
    .wdata      (bus.writecop0),
    .count      (count_val),
    .compare    (compare_val),
    .timer_flag (timer_flag)
  );
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign timer_flag  = 1'b0;
`endif

  // The timer shares the top interrupt line with external source NUM_IRQ-1.
  always_comb begin
    ip = bus.interrupts;
    ip[NUM_IRQ-1] = bus.interrupts[NUM_IRQ-1] | timer_flag;
  end

  assign interrupt = (|(ip & im)) & ie & ~exl_q;
  assign sync_req  = bus.overflow | bus.adel | bus.ades | bus.syscall | bus.break_ | bus.ri;
  assign pending   = interrupt | sync_req;
  assign win_code  = exc_code_sel(interrupt, bus.overflow, bus.adel, bus.ades,
                                  bus.syscall, bus.break_, bus.ri);

  assign bus.pendingexception = pending;
  assign bus.epc              = epc_q;
  assign bus.exl              = exl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ie       <= 1'b0;
      exl_q    <= 1'b0;
      im       <= '0;
      exc_code <= '0;
      epc_q    <= '0;
    end else begin
      if (bus.cop0write && bus.writeaddress == REG_STATUS) begin
        ie <= bus.writecop0[STATUS_IE];
        im <= bus.writecop0[STATUS_IM_LSB +: NUM_IRQ];
      end
      // A taken exception overrides eret and any mtc0 to EPC on the same edge.
      if (pending) begin
        exl_q    <= 1'b1;
        exc_code <= win_code;
        if (!exl_q) epc_q <= bus.pc;
      end else begin
        if (bus.eret) exl_q <= 1'b0;
        if (bus.cop0write && bus.writeaddress == REG_EPC) epc_q <= bus.writecop0;
      end
    end
  end

  always_comb begin
    status_rd = '0;
    status_rd[STATUS_IE]  = ie;
    status_rd[STATUS_EXL] = exl_q;
    status_rd[STATUS_IM_LSB +: NUM_IRQ] = im;
    cause_rd = '0;
    cause_rd[CAUSE_EXC_LSB +: 5] = exc_code;
    cause_rd[CAUSE_IP_LSB +: NUM_IRQ] = ip;
  end

  always_comb begin
    case (bus.readaddress)
      REG_COUNT:   bus.cop0readdata = count_val;
      REG_COMPARE: bus.cop0readdata = compare_val;
      REG_STATUS:  bus.cop0readdata = status_rd;
      REG_CAUSE:   bus.cop0readdata = cause_rd;
      REG_EPC:     bus.cop0readdata = epc_q;
      default:     bus.cop0readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed bench for cp0_exception_ctrl; timer scenario compiled only with CP0_TIMER_EN.
module tb_cp0_exception_ctrl;
  import cp0_pkg::*;

  localparam int DW = 32;
  localparam int NI = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cp0_exception_ctrl_if #(.DATA_WIDTH(DW), .NUM_IRQ(NI)) bus ();

  cp0_exception_ctrl #(.DATA_WIDTH(DW), .NUM_IRQ(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.interrupts   = '0;
    bus.cop0write    = 1'b0;
    bus.writeaddress = '0;
    bus.writecop0    = '0;
    bus.overflow     = 1'b0;
    bus.adel         = 1'b0;
    bus.ades         = 1'b0;
    bus.syscall      = 1'b0;
    bus.break_       = 1'b0;
    bus.ri           = 1'b0;
    bus.eret         = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [DW-1:0] d);
    bus.cop0write    = 1'b1;
    bus.writeaddress = a;
    bus.writecop0    = d;
    tick();
    bus.cop0write    = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    bus.readaddress = a;
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.pc = 32'h123;
    bus.readaddress = '0;
    reset = 1'b1;
    bus.cop0write = 1'b1; bus.writeaddress = REG_STATUS; bus.writecop0 = 32'h0101;
    bus.overflow = 1'b1; bus.interrupts = 8'hFF;
    tick();
    tick();
    idle();
    reset = 1'b0;
    #1;
    checks++; if (bus.exl !== 1'b0) begin errors++; $display("FAIL reset_exl: got %0h expected 0", bus.exl); end
    checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %0h expected 0", bus.epc); end
    checks++; if (bus.pendingexception !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0h expected 0", bus.pendingexception); end
    rd(REG_STATUS);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL reset_status: got %0h expected 0", bus.cop0readdata); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL reset_cause: got %0h expected 0", bus.cop0readdata); end
    rd(REG_EPC);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL reset_epc_rd: got %0h expected 0", bus.cop0readdata); end
    rd(5'd3);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL reset_unmapped: got %0h expected 0", bus.cop0readdata); end
    rd(REG_COMPARE);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL reset_compare: got %0h expected 0", bus.cop0readdata); end
  endtask

  task automatic test_interrupt();
    mtc0(REG_STATUS, 32'h0101);
    rd(REG_STATUS);
    checks++; if (bus.cop0readdata !== 32'h0101) begin errors++; $display("FAIL irq_status_wr: got %0h expected 101", bus.cop0readdata); end
    bus.interrupts = 8'h01; bus.pc = 32'h400;
    #1;
    checks++; if (bus.pendingexception !== 1'b1) begin errors++; $display("FAIL irq_pending: got %0h expected 1", bus.pendingexception); end
    tick();
    checks++; if (bus.exl !== 1'b1) begin errors++; $display("FAIL irq_exl: got %0h expected 1", bus.exl); end
    checks++; if (bus.epc !== 32'h400) begin errors++; $display("FAIL irq_epc: got %0h expected 400", bus.epc); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h100) begin errors++; $display("FAIL irq_cause: got %0h expected 100", bus.cop0readdata); end
    rd(REG_STATUS);
    checks++; if (bus.cop0readdata !== 32'h0103) begin errors++; $display("FAIL irq_status_exl: got %0h expected 103", bus.cop0readdata); end
    checks++; if (bus.pendingexception !== 1'b0) begin errors++; $display("FAIL irq_masked_by_exl: got %0h expected 0", bus.pendingexception); end
    bus.pc = 32'h500;
    tick();
    checks++; if (bus.epc !== 32'h400) begin errors++; $display("FAIL irq_epc_hold: got %0h expected 400", bus.epc); end
    bus.interrupts = '0;
  endtask

  task automatic test_eret();
    bus.eret = 1'b1;
    #1;
    checks++; if (bus.pendingexception !== 1'b0) begin errors++; $display("FAIL eret_pending: got %0h expected 0", bus.pendingexception); end
    tick();
    idle();
    #1;
    checks++; if (bus.exl !== 1'b0) begin errors++; $display("FAIL eret_exl: got %0h expected 0", bus.exl); end
  endtask

  task automatic test_mask();
    bus.interrupts = 8'h02;
    #1;
    checks++; if (bus.pendingexception !== 1'b0) begin errors++; $display("FAIL mask_im: got %0h expected 0", bus.pendingexception); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h200) begin errors++; $display("FAIL mask_ip: got %0h expected 200", bus.cop0readdata); end
    bus.interrupts = '0;
    mtc0(REG_STATUS, 32'h0100);
    bus.interrupts = 8'h01;
    #1;
    checks++; if (bus.pendingexception !== 1'b0) begin errors++; $display("FAIL mask_ie: got %0h expected 0", bus.pendingexception); end
    bus.interrupts = '0;
    #1;
  endtask

  task automatic test_priority();
    bus.overflow = 1'b1; bus.syscall = 1'b1; bus.pc = 32'h200;
    #1;
    checks++; if (bus.pendingexception !== 1'b1) begin errors++; $display("FAIL prio_pending: got %0h expected 1", bus.pendingexception); end
    tick();
    idle();
    #1;
    checks++; if (bus.exl !== 1'b1) begin errors++; $display("FAIL prio_exl: got %0h expected 1", bus.exl); end
    checks++; if (bus.epc !== 32'h200) begin errors++; $display("FAIL prio_epc: got %0h expected 200", bus.epc); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h30) begin errors++; $display("FAIL prio_ov_over_sys: got %0h expected 30", bus.cop0readdata); end
    bus.ri = 1'b1; bus.pc = 32'h300;
    tick();
    idle();
    #1;
    checks++; if (bus.epc !== 32'h200) begin errors++; $display("FAIL nested_epc_hold: got %0h expected 200", bus.epc); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h28) begin errors++; $display("FAIL nested_ri_code: got %0h expected 28", bus.cop0readdata); end
    bus.adel = 1'b1; bus.ades = 1'b1; bus.ri = 1'b1;
    tick();
    idle();
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h10) begin errors++; $display("FAIL prio_adel: got %0h expected 10", bus.cop0readdata); end
    bus.ades = 1'b1; bus.syscall = 1'b1; bus.break_ = 1'b1;
    tick();
    idle();
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h14) begin errors++; $display("FAIL prio_ades: got %0h expected 14", bus.cop0readdata); end
  endtask

  task automatic test_eret_break();
    bus.eret = 1'b1; bus.break_ = 1'b1; bus.pc = 32'h600;
    tick();
    idle();
    #1;
    checks++; if (bus.exl !== 1'b1) begin errors++; $display("FAIL eret_break_exl: got %0h expected 1", bus.exl); end
    checks++; if (bus.epc !== 32'h200) begin errors++; $display("FAIL eret_break_epc: got %0h expected 200", bus.epc); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h24) begin errors++; $display("FAIL eret_break_code: got %0h expected 24", bus.cop0readdata); end
  endtask

  task automatic test_mtc0_collision();
    bus.eret = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (bus.exl !== 1'b0) begin errors++; $display("FAIL coll_eret_exl: got %0h expected 0", bus.exl); end
    mtc0(REG_EPC, 32'hABC);
    rd(REG_EPC);
    checks++; if (bus.cop0readdata !== 32'hABC) begin errors++; $display("FAIL epc_write: got %0h expected abc", bus.cop0readdata); end
    bus.cop0write = 1'b1; bus.writeaddress = REG_STATUS; bus.writecop0 = 32'hFF00;
    bus.ades = 1'b1; bus.pc = 32'h700;
    tick();
    idle();
    #1;
    checks++; if (bus.epc !== 32'h700) begin errors++; $display("FAIL coll_status_epc: got %0h expected 700", bus.epc); end
    rd(REG_STATUS);
    checks++; if (bus.cop0readdata !== 32'hFF02) begin errors++; $display("FAIL coll_status: got %0h expected ff02", bus.cop0readdata); end
    bus.eret = 1'b1;
    tick();
    idle();
    bus.cop0write = 1'b1; bus.writeaddress = REG_EPC; bus.writecop0 = 32'h111;
    bus.syscall = 1'b1; bus.pc = 32'h800;
    tick();
    idle();
    #1;
    checks++; if (bus.epc !== 32'h800) begin errors++; $display("FAIL coll_epc_exc_wins: got %0h expected 800", bus.epc); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h20) begin errors++; $display("FAIL coll_sys_code: got %0h expected 20", bus.cop0readdata); end
    mtc0(REG_CAUSE, 32'hFFFF);
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h20) begin errors++; $display("FAIL cause_readonly: got %0h expected 20", bus.cop0readdata); end
    bus.eret = 1'b1;
    tick();
    idle();
    mtc0(REG_STATUS, 32'h0002);
    rd(REG_STATUS);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL exl_not_writable: got %0h expected 0", bus.cop0readdata); end
`ifndef CP0_TIMER_EN
    mtc0(REG_COMPARE, 32'h55);
    rd(REG_COMPARE);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL no_timer_compare: got %0h expected 0", bus.cop0readdata); end
    mtc0(REG_COUNT, 32'h77);
    rd(REG_COUNT);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL no_timer_count: got %0h expected 0", bus.cop0readdata); end
`endif
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    mtc0(REG_STATUS, 32'h8001);
    mtc0(REG_COMPARE, 32'd5);
    mtc0(REG_COUNT, 32'd0);
    rd(REG_COUNT);
    checks++; if (bus.cop0readdata !== 32'd0) begin errors++; $display("FAIL timer_count_load: got %0h expected 0", bus.cop0readdata); end
    repeat (4) tick();
    rd(REG_COUNT);
    checks++; if (bus.cop0readdata !== 32'd4) begin errors++; $display("FAIL timer_count_4: got %0h expected 4", bus.cop0readdata); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL timer_ip_early: got %0h expected 0", bus.cop0readdata); end
    tick();
    rd(REG_COUNT);
    checks++; if (bus.cop0readdata !== 32'd5) begin errors++; $display("FAIL timer_count_5: got %0h expected 5", bus.cop0readdata); end
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h8000) begin errors++; $display("FAIL timer_ip7: got %0h expected 8000", bus.cop0readdata); end
    checks++; if (bus.pendingexception !== 1'b1) begin errors++; $display("FAIL timer_pending: got %0h expected 1", bus.pendingexception); end
    mtc0(REG_COMPARE, 32'h100);
    rd(REG_CAUSE);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL timer_clear: got %0h expected 0", bus.cop0readdata); end
    checks++; if (bus.exl !== 1'b1) begin errors++; $display("FAIL timer_exl: got %0h expected 1", bus.exl); end
    mtc0(REG_COUNT, 32'hFFFF_FFFF);
    rd(REG_COUNT);
    checks++; if (bus.cop0readdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_all_ones: got %0h expected ffffffff", bus.cop0readdata); end
    tick();
    rd(REG_COUNT);
    checks++; if (bus.cop0readdata !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %0h expected 0", bus.cop0readdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_interrupt();
    test_eret();
    test_mask();
    test_priority();
    test_eret_break();
    test_mtc0_collision();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
